alu_ram_sequencer: RTL and testbench

- Instruction sequencer placed in front of the ALU + dual-port RAM datapath.
- Buffers incoming ALU instructions in a small FIFO, then runs them one at a time through four phases: read operands, execute, optional write-back of Z, respond.
- Drives the datapath address/opcode/WE_Z inputs and returns result + comparator flags over a valid/ready response channel.
- Strictly in-order; one instruction in flight.

---
 rtl/alu_ram_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_ram_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ram_sequencer.sv
// ---------------------------------------------------------------------------
// alu_ram_sequencer
//   In-order instruction sequencer in front of an ALU + dual-port RAM
//   datapath. Instructions are buffered in a DEPTH-entry FIFO and executed
//   one at a time: read operands, execute/capture, optional Z write-back,
//   then a valid/ready response.
//
// Ports
//   CLK, RST           clock, synchronous active-high reset
//   instr_*            instruction push channel (valid/ready)
//   dp_addr_a/b/z      datapath RAM addresses
//   dp_opcode, dp_cin  datapath ALU controls
//   dp_we_z            datapath Z write enable (high only in WRITE)
//   dp_z, dp_flags     datapath result and comparator flags {XBY,YBX,XEY}
//   res_*              response channel (valid/ready) with captured result
//   busy               FSM active or FIFO non-empty
//   op_count           completed-response counter (wraps)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting; pops FIFO head into current-op registers when non-empty
// READ  | dp_* driven from current op; one settle cycle for the RAM read
// EXEC  | capture dp_z / dp_flags / addr_z into the response registers
// WRITE | dp_we_z high for this one cycle; RAM writes Z at the exiting edge
// RESP  | res_valid high; response held until res_valid & res_ready
// ---------------------------------------------------------------------------
module alu_ram_sequencer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_opcode,
  input  logic              instr_cin,
  input  logic [ADDR_W-1:0] instr_addr_a,
  input  logic [ADDR_W-1:0] instr_addr_b,
  input  logic [ADDR_W-1:0] instr_addr_z,
  input  logic              instr_wb,
  output logic [ADDR_W-1:0] dp_addr_a,
  output logic [ADDR_W-1:0] dp_addr_b,
  output logic [ADDR_W-1:0] dp_addr_z,
  output logic [3:0]        dp_opcode,
  output logic              dp_cin,
  output logic              dp_we_z,
  input  logic [DATA_W-1:0] dp_z,
  input  logic [2:0]        dp_flags,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_z,
  output logic [2:0]        res_flags,
  output logic [ADDR_W-1:0] res_addr_z,
  output logic              busy,
  output logic [15:0]       op_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0]        opcode;
    logic              cin;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_z;
    logic              wb;
  } instr_t;

  instr_t           fifo_mem [DEPTH];
  instr_t           in_word;
  instr_t           cur_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             fifo_nempty;
  state_t           state_q;
  state_t           state_d;

  assign in_word = '{opcode: instr_opcode, cin: instr_cin, addr_a: instr_addr_a,
                     addr_b: instr_addr_b, addr_z: instr_addr_z, wb: instr_wb};

  // Ready is a function of occupancy only, so a same-cycle pop never
  // creates a combinational path from the FSM to the producer.
  assign instr_ready = (count != FULL);
  assign push        = instr_valid & instr_ready;
  assign fifo_nempty = (count != '0);

  // ---------------- next state / outputs ----------------
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    dp_we_z   = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_nempty) begin
          pop     = 1'b1;
          state_d = READ;
        end
      end
      READ:  state_d = EXEC;
      EXEC:  state_d = cur_q.wb ? WRITE : RESP;
      WRITE: begin
        dp_we_z = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE) | fifo_nempty;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- instruction FIFO ----------------
  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= in_word;
  end

  // Pointer widths equal log2(DEPTH), so wrap-around is implicit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- current op / datapath drive ----------------
  // Loading at the pop edge makes dp_* valid for the whole of READ and
  // holds them unchanged through EXEC, WRITE, RESP and the following IDLE.
  always_ff @(posedge CLK) begin
    if (RST)      cur_q <= '0;
    else if (pop) cur_q <= fifo_mem[rd_ptr];
  end

  assign dp_addr_a = cur_q.addr_a;
  assign dp_addr_b = cur_q.addr_b;
  assign dp_addr_z = cur_q.addr_z;
  assign dp_opcode = cur_q.opcode;
  assign dp_cin    = cur_q.cin;

  // ---------------- response path ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_z      <= '0;
      res_flags  <= '0;
      res_addr_z <= '0;
    end else if (state_q == EXEC) begin
      res_z      <= dp_z;
      res_flags  <= dp_flags;
      res_addr_z <= cur_q.addr_z;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)                               op_count <= '0;
    else if ((state_q == RESP) && res_ready) op_count <= op_count + 16'd1;
  end

endmodule

// File: tb/tb_alu_ram_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_ram_sequencer
//   Directed bench for alu_ram_sequencer. Includes a behavioural ALU + RAM
//   datapath (opcodes: 0 ADD, 1 SUB, 2 AND, 3 XOR, others OR; flags are
//   {A>B, B>A, A==B}) so results and write-backs are observable.
// ---------------------------------------------------------------------------
module tb_alu_ram_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_opcode = '0;
  logic       instr_cin = 1'b0;
  logic [7:0] instr_addr_a = '0;
  logic [7:0] instr_addr_b = '0;
  logic [7:0] instr_addr_z = '0;
  logic       instr_wb = 1'b0;
  logic [7:0] dp_addr_a, dp_addr_b, dp_addr_z;
  logic [3:0] dp_opcode;
  logic       dp_cin, dp_we_z;
  logic [7:0] dp_z;
  logic [2:0] dp_flags;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_z;
  logic [2:0] res_flags;
  logic [7:0] res_addr_z;
  logic       busy;
  logic [15:0] op_count;

  always #5 CLK = ~CLK;

  alu_ram_sequencer #(.DEPTH(4), .ADDR_W(8), .DATA_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_cin(instr_cin),
    .instr_addr_a(instr_addr_a), .instr_addr_b(instr_addr_b),
    .instr_addr_z(instr_addr_z), .instr_wb(instr_wb),
    .dp_addr_a(dp_addr_a), .dp_addr_b(dp_addr_b), .dp_addr_z(dp_addr_z),
    .dp_opcode(dp_opcode), .dp_cin(dp_cin), .dp_we_z(dp_we_z),
    .dp_z(dp_z), .dp_flags(dp_flags),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_flags(res_flags), .res_addr_z(res_addr_z),
    .busy(busy), .op_count(op_count)
  );

  // ---------------- datapath model ----------------
  logic [7:0] ram [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_waddr = '0;
  logic [7:0] tb_wdata = '0;
  logic [7:0] op_x, op_y;

  always_comb begin
    op_x = ram[dp_addr_a];
    op_y = ram[dp_addr_b];
    case (dp_opcode)
      4'd0:    dp_z = op_x + op_y + {7'd0, dp_cin};
      4'd1:    dp_z = op_x - op_y;
      4'd2:    dp_z = op_x & op_y;
      4'd3:    dp_z = op_x ^ op_y;
      default: dp_z = op_x | op_y;
    endcase
    dp_flags = {op_x > op_y, op_y > op_x, op_x == op_y};
  end

  always @(posedge CLK) begin
    if (dp_we_z)    ram[dp_addr_z] <= dp_z;
    else if (tb_we) ram[tb_waddr]  <= tb_wdata;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int exp_ops  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(posedge CLK); #1;
    tb_we = 1'b0;
  endtask

  task automatic push(input logic [3:0] op, input logic cin, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] z, input logic wb);
    instr_opcode = op; instr_cin = cin; instr_addr_a = a;
    instr_addr_b = b; instr_addr_z = z; instr_wb = wb;
    instr_valid = 1'b1;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
  endtask

  // Counts edges until res_valid is seen after an edge; also counts
  // cycles in which dp_we_z was high along the way.
  task automatic wait_result(output int lat, output int we_cnt, output bit ok);
    lat = 0; we_cnt = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
      if (dp_we_z) we_cnt++;
    end while (!res_valid && lat < 40);
    ok = res_valid;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
    exp_ops++;
  endtask

  typedef struct {
    logic [3:0] op;
    logic       cin;
    logic [7:0] a, b, z;
    logic       wb;
    logic [7:0] va, vb, ez;
    logic [2:0] ef;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got hang, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int  lat, wecnt, accepted, got;
    bit  ok, rdy;

    vecs[0] = '{4'd0, 1'b0, 8'd1,   8'd2,   8'd3,   1'b1, 8'h05, 8'h03, 8'h08, 3'b100};
    vecs[1] = '{4'd0, 1'b0, 8'd1,   8'd2,   8'd3,   1'b0, 8'h05, 8'h03, 8'h08, 3'b100};
    vecs[2] = '{4'd0, 1'b1, 8'd10,  8'd11,  8'd12,  1'b1, 8'hFF, 8'h01, 8'h01, 3'b100};
    vecs[3] = '{4'd1, 1'b0, 8'd20,  8'd21,  8'd22,  1'b1, 8'h03, 8'h05, 8'hFE, 3'b010};
    vecs[4] = '{4'd2, 1'b0, 8'd30,  8'd31,  8'd32,  1'b0, 8'h5A, 8'h5A, 8'h5A, 3'b001};
    vecs[5] = '{4'd3, 1'b0, 8'd40,  8'd41,  8'd42,  1'b1, 8'hF0, 8'h3C, 8'hCC, 3'b100};
    vecs[6] = '{4'd4, 1'b0, 8'hFE,  8'hFF,  8'h00,  1'b1, 8'h80, 8'h01, 8'h81, 3'b100};

    // ---------------- reset state ----------------
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_instr_ready", 32'(instr_ready), 32'd1);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_res_valid",   32'(res_valid),   32'd0);
    check("rst_op_count",    32'(op_count),    32'd0);
    check("rst_dp_we_z",     32'(dp_we_z),     32'd0);
    check("rst_dp_addr_a",   32'(dp_addr_a),   32'd0);
    check("rst_res_z",       32'(res_z),       32'd0);

    // ---------------- single-op vectors ----------------
    for (int i = 0; i < NV; i++) begin
      preload(vecs[i].a, vecs[i].va);
      preload(vecs[i].b, vecs[i].vb);
      preload(vecs[i].z, 8'hA5);
      push(vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].wb);
      wait_result(lat, wecnt, ok);
      check($sformatf("v%0d_res_valid", i), 32'(ok),  32'd1);
      check($sformatf("v%0d_latency", i),   32'(lat), vecs[i].wb ? 32'd4 : 32'd3);
      check($sformatf("v%0d_res_z", i),     32'(res_z),      32'(vecs[i].ez));
      check($sformatf("v%0d_res_flags", i), 32'(res_flags),  32'(vecs[i].ef));
      check($sformatf("v%0d_res_addr_z", i),32'(res_addr_z), 32'(vecs[i].z));
      check($sformatf("v%0d_dp_addr_z", i), 32'(dp_addr_z),  32'(vecs[i].z));
      check($sformatf("v%0d_we_cycles", i), 32'(wecnt), vecs[i].wb ? 32'd1 : 32'd0);
      handshake();
      check($sformatf("v%0d_op_count", i),  32'(op_count), 32'(exp_ops));
      check($sformatf("v%0d_ram_z", i),     32'(ram[vecs[i].z]),
            vecs[i].wb ? 32'(vecs[i].ez) : 32'h0A5);
      check($sformatf("v%0d_busy_after", i),32'(busy), 32'd0);
    end

    // ---------------- FIFO full with backpressure ----------------
    preload(8'd50, 8'h10);
    preload(8'd51, 8'h20);
    res_ready = 1'b0;
    accepted  = 0;
    for (int c = 0; c < 8; c++) begin
      instr_opcode = 4'd0; instr_cin = 1'b0; instr_addr_a = 8'd50;
      instr_addr_b = 8'd51; instr_addr_z = 8'(100 + accepted); instr_wb = 1'b0;
      instr_valid  = 1'b1;
      rdy = instr_ready;
      @(posedge CLK); #1;
      if (rdy) accepted++;
    end
    instr_valid = 1'b0;
    check("full_accepted",    32'(accepted),    32'd5);
    check("full_instr_ready", 32'(instr_ready), 32'd0);
    check("full_busy",        32'(busy),        32'd1);
    res_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 80 && got < 5; c++) begin
      if (res_valid) begin
        check($sformatf("drain%0d_addr_z", got), 32'(res_addr_z), 32'(100 + got));
        check($sformatf("drain%0d_res_z", got),  32'(res_z), 32'h30);
        check($sformatf("drain%0d_flags", got),  32'(res_flags), 32'b010);
        got++;
      end
      @(posedge CLK); #1;
    end
    res_ready = 1'b0;
    exp_ops += 5;
    check("drain_count",    32'(got),      32'd5);
    check("drain_op_count", 32'(op_count), 32'(exp_ops));
    check("drain_ready",    32'(instr_ready), 32'd1);
    push(4'd0, 1'b0, 8'd50, 8'd51, 8'd105, 1'b0);
    wait_result(lat, wecnt, ok);
    check("sixth_valid",  32'(ok), 32'd1);
    check("sixth_addr_z", 32'(res_addr_z), 32'd105);
    handshake();

    // ---------------- RAW chain, 10 back-to-back ----------------
    preload(8'd59, 8'h01);
    preload(8'd60, 8'h01);
    fork
      begin : pusher
        int g;
        bit r;
        g = 0;
        for (int k = 0; k < 10; k++) begin
          instr_opcode = 4'd0; instr_cin = 1'b0; instr_addr_a = 8'(60 + k);
          instr_addr_b = 8'd59; instr_addr_z = 8'(61 + k); instr_wb = 1'b1;
          instr_valid  = 1'b1;
          do begin
            r = instr_ready;
            @(posedge CLK); #1;
            g++;
          end while (!r && g < 300);
        end
        instr_valid = 1'b0;
      end
      begin : collector
        int n, g;
        n = 0; g = 0;
        res_ready = 1'b1;
        while (n < 10 && g < 400) begin
          if (res_valid) begin
            check($sformatf("raw%0d_res_z", n),  32'(res_z), 32'(n + 2));
            check($sformatf("raw%0d_addr_z", n), 32'(res_addr_z), 32'(61 + n));
            n++;
          end
          @(posedge CLK); #1;
          g++;
        end
        res_ready = 1'b0;
        check("raw_count", 32'(n), 32'd10);
      end
    join
    exp_ops += 10;
    check("raw_final_ram", 32'(ram[70]), 32'd11);
    check("raw_op_count",  32'(op_count), 32'(exp_ops));

    // ---------------- held response under backpressure ----------------
    preload(8'd80, 8'h09);
    preload(8'd81, 8'h04);
    preload(8'd83, 8'h02);
    preload(8'd84, 8'h07);
    push(4'd0, 1'b0, 8'd80, 8'd81, 8'd82, 1'b1);
    push(4'd1, 1'b0, 8'd83, 8'd84, 8'd85, 1'b0);
    wait_result(lat, wecnt, ok);
    check("bp_first_valid", 32'(ok), 32'd1);
    for (int c = 0; c < 7; c++) begin
      @(posedge CLK); #1;
      check($sformatf("bp%0d_valid", c),  32'(res_valid),  32'd1);
      check($sformatf("bp%0d_res_z", c),  32'(res_z),      32'h0D);
      check($sformatf("bp%0d_flags", c),  32'(res_flags),  32'b100);
      check($sformatf("bp%0d_addr_z", c), 32'(res_addr_z), 32'd82);
      check($sformatf("bp%0d_no_pop", c), 32'(dp_addr_a),  32'd80);
    end
    handshake();
    wait_result(lat, wecnt, ok);
    check("bp_second_latency", 32'(lat), 32'd3);
    check("bp_second_res_z",   32'(res_z), 32'hFB);
    check("bp_second_flags",   32'(res_flags), 32'b010);
    check("bp_second_addr_z",  32'(res_addr_z), 32'd85);
    handshake();
    check("bp_op_count", 32'(op_count), 32'(exp_ops));

    // ---------------- reset mid-EXEC with two queued ----------------
    preload(8'd90, 8'hA5);
    preload(8'd91, 8'h01);
    preload(8'd92, 8'h02);
    push(4'd0, 1'b0, 8'd91, 8'd92, 8'd90, 1'b1);
    push(4'd0, 1'b0, 8'd91, 8'd92, 8'd90, 1'b1);
    push(4'd0, 1'b0, 8'd91, 8'd92, 8'd90, 1'b1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("mrst_res_valid",   32'(res_valid),   32'd0);
    check("mrst_dp_we_z",     32'(dp_we_z),     32'd0);
    check("mrst_op_count",    32'(op_count),    32'd0);
    check("mrst_busy",        32'(busy),        32'd0);
    check("mrst_instr_ready", 32'(instr_ready), 32'd1);
    check("mrst_dp_addr_a",   32'(dp_addr_a),   32'd0);
    got = 0; wecnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      if (res_valid) got++;
      if (dp_we_z)   wecnt++;
    end
    check("mrst_no_result", 32'(got),     32'd0);
    check("mrst_no_write",  32'(wecnt),   32'd0);
    check("mrst_ram_kept",  32'(ram[90]), 32'h0A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
